// File: rtl/int_controller_if.sv
// Bus between the control unit and the interrupt controller.
// master = control unit side, slave = interrupt controller side.
interface int_controller_if #(
   parameter int unsigned PC_W = 10
);
   logic [3:0]      irq;
   logic            mask_we;
   logic [3:0]      mask_in;
   logic            inst_boundary;
   logic [PC_W-1:0] pc_in;
   logic            reti;
   logic            int_take;
   logic [PC_W-1:0] vec_addr;
   logic [PC_W-1:0] ret_addr;
   logic            in_service;
   logic [1:0]      active_id;
   logic [3:0]      pending;

   modport master (
      output irq, mask_we, mask_in, inst_boundary, pc_in, reti,
      input  int_take, vec_addr, ret_addr, in_service, active_id, pending
   );

   modport slave (
      input  irq, mask_we, mask_in, inst_boundary, pc_in, reti,
      output int_take, vec_addr, ret_addr, in_service, active_id, pending
   );
endinterface

// File: rtl/int_controller.sv
// Four-source, edge-triggered, fixed-priority, non-nesting interrupt controller.
// Takes an interrupt at an instruction boundary and holds it until reti.
module int_controller #(
   parameter int unsigned     PC_W     = 10,
   parameter logic [PC_W-1:0] VEC_BASE = PC_W'(10'h3C0)
) (
   input logic              clk,
   input logic              reset,
   int_controller_if.slave  bus
);
   localparam int unsigned N_SRC = 4;
   localparam int unsigned ID_W  = 2;

   typedef enum logic {
      IDLE    = 1'b0,
      SERVICE = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [N_SRC-1:0]  irq_q;
   logic [N_SRC-1:0]  mask;
   logic [N_SRC-1:0]  pending;
   logic [N_SRC-1:0]  rise_c;
   logic [N_SRC-1:0]  eligible_c;
   logic [N_SRC-1:0]  clr_c;
   logic [N_SRC-1:0]  pending_nxt;

   logic              take_c;
   logic [ID_W-1:0]   id_c;
   logic [PC_W-1:0]   vec_nxt;
   logic              in_service_nxt;

   logic              int_take_q;
   logic [PC_W-1:0]   vec_addr_q;
   logic [PC_W-1:0]   ret_addr_q;
   logic              in_service_q;
   logic [ID_W-1:0]   active_id_q;

   // Edge detect and eligibility; mask is the registered value, so a
   // mask write never influences a take decided at the same edge.
   assign rise_c     = bus.irq & ~irq_q;
   assign eligible_c = pending & mask;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if ((eligible_c != '0) && bus.inst_boundary) begin
               state_nxt = SERVICE;
            end
         end
         SERVICE: begin
            if (bus.reti) begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // Output / datapath decode: priority select, vector, pending update
   always_comb begin
      take_c         = 1'b0;
      id_c           = '0;
      vec_nxt        = vec_addr_q;
      clr_c          = '0;
      pending_nxt    = pending;
      in_service_nxt = 1'b0;

      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (eligible_c[i]) begin
            id_c = ID_W'(i);
         end
      end

      if ((state == IDLE) && (eligible_c != '0) && bus.inst_boundary) begin
         take_c  = 1'b1;
         vec_nxt = VEC_BASE + PC_W'({id_c, 2'b00});
         clr_c   = N_SRC'(1) << id_c;
      end

      // A fresh edge on the source being taken wins over its clear
      pending_nxt    = (pending & ~clr_c) | rise_c;
      in_service_nxt = (state_nxt == SERVICE);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q        <= '0;
         mask         <= '0;
         pending      <= '0;
         int_take_q   <= 1'b0;
         vec_addr_q   <= '0;
         ret_addr_q   <= '0;
         in_service_q <= 1'b0;
         active_id_q  <= '0;
      end else begin
         irq_q        <= bus.irq;
         pending      <= pending_nxt;
         int_take_q   <= take_c;
         in_service_q <= in_service_nxt;
         if (bus.mask_we) begin
            mask <= bus.mask_in;
         end
         if (take_c) begin
            vec_addr_q  <= vec_nxt;
            ret_addr_q  <= bus.pc_in;
            active_id_q <= id_c;
         end
      end
   end

   assign bus.int_take   = int_take_q;
   assign bus.vec_addr   = vec_addr_q;
   assign bus.ret_addr   = ret_addr_q;
   assign bus.in_service = in_service_q;
   assign bus.active_id  = active_id_q;
   assign bus.pending    = pending;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_int_controller;
   localparam int unsigned     PC_W     = 10;
   localparam logic [PC_W-1:0] VEC_BASE = 10'h3C0;

   logic clk = 1'b0;
   logic reset;
   logic cmp_en = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   int_controller_if #(.PC_W(PC_W)) bus();

   int_controller #(.PC_W(PC_W), .VEC_BASE(VEC_BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [3:0]      m_pending, m_mask, m_irq_prev, m_rises, m_elig;
   logic            m_busy, m_take;
   logic [PC_W-1:0] m_vec, m_ret;
   logic [1:0]      m_id;
   int              m_low, m_sel;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pending = 0; m_mask = 0; m_irq_prev = 0;
         m_busy = 0; m_take = 0; m_vec = 0; m_ret = 0; m_id = 0;
      end else begin
         m_rises    = bus.irq & ~m_irq_prev;
         m_irq_prev = bus.irq;
         m_elig     = m_pending & m_mask;
         m_take     = 0;
         if (!m_busy && m_elig != 0 && bus.inst_boundary) begin
            // lowest set bit is the highest priority
            m_low     = int'(m_elig) & -int'(m_elig);
            m_sel     = $clog2(m_low);
            m_take    = 1;
            m_busy    = 1;
            m_id      = 2'(m_sel);
            m_ret     = bus.pc_in;
            m_vec     = VEC_BASE + PC_W'(m_sel * 4);
            m_pending = m_pending & ~4'(m_low);
         end else if (m_busy && bus.reti) begin
            m_busy = 0;
         end
         m_pending = m_pending | m_rises;
         if (bus.mask_we) m_mask = bus.mask_in;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      #1;
      if (cmp_en) begin
         chk("cmp int_take",   32'(bus.int_take),   32'(m_take));
         chk("cmp in_service", 32'(bus.in_service), 32'(m_busy));
         chk("cmp pending",    32'(bus.pending),    32'(m_pending));
         chk("cmp vec_addr",   32'(bus.vec_addr),   32'(m_vec));
         chk("cmp ret_addr",   32'(bus.ret_addr),   32'(m_ret));
         chk("cmp active_id",  32'(bus.active_id),  32'(m_id));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.irq = 0; bus.mask_we = 0; bus.mask_in = 0;
      bus.inst_boundary = 0; bus.pc_in = 0; bus.reti = 0;
   endtask

   task automatic set_mask(input logic [3:0] m);
      bus.mask_we = 1; bus.mask_in = m;
      cyc();
      bus.mask_we = 0;
   endtask

   task automatic do_reti();
      bus.inst_boundary = 0; bus.reti = 1;
      cyc();
      bus.reti = 0;
   endtask

   int takes;

   initial begin
      reset = 1;
      idle_inputs();
      repeat (2) cyc();
      reset = 0;
      cmp_en = 1;
      cyc();
      chk("reset int_take", 32'(bus.int_take), 0);
      chk("reset pending",  32'(bus.pending), 0);
      chk("reset vec_addr", 32'(bus.vec_addr), 0);

      // Single source take
      set_mask(4'hF);
      bus.irq = 4'b0100;
      cyc();
      bus.irq = 0; bus.inst_boundary = 1; bus.pc_in = 10'h015;
      cyc();
      chk("t1 int_take",   32'(bus.int_take), 1);
      chk("t1 vec_addr",   32'(bus.vec_addr), 32'h3C8);
      chk("t1 ret_addr",   32'(bus.ret_addr), 32'h015);
      chk("t1 active_id",  32'(bus.active_id), 2);
      chk("t1 pending2",   32'(bus.pending[2]), 0);
      chk("t1 in_service", 32'(bus.in_service), 1);
      do_reti();
      chk("t1 reti in_service", 32'(bus.in_service), 0);

      // Simultaneous requests resolve by priority, then back-to-back
      bus.irq = 4'b1010;
      cyc();
      bus.irq = 0; bus.inst_boundary = 1; bus.pc_in = 10'h100;
      cyc();
      chk("t2 take1",   32'(bus.int_take), 1);
      chk("t2 id1",     32'(bus.active_id), 1);
      chk("t2 vec1",    32'(bus.vec_addr), 32'h3C4);
      chk("t2 pending", 32'(bus.pending), 32'b1000);
      do_reti();
      chk("t2 in_service drop", 32'(bus.in_service), 0);
      bus.inst_boundary = 1; bus.pc_in = 10'h101;
      cyc();
      chk("t2 take3", 32'(bus.int_take), 1);
      chk("t2 id3",   32'(bus.active_id), 3);
      chk("t2 vec3",  32'(bus.vec_addr), 32'h3CC);
      chk("t2 ret3",  32'(bus.ret_addr), 32'h101);
      do_reti();

      // Masked request stays latched, taken once unmasked
      set_mask(4'b0000);
      bus.irq = 4'b0001; bus.inst_boundary = 1;
      cyc();
      bus.irq = 0;
      cyc();
      chk("t3 pending masked", 32'(bus.pending), 32'b0001);
      chk("t3 no take",        32'(bus.int_take), 0);
      cyc();
      chk("t3 still no take",  32'(bus.int_take), 0);
      bus.mask_we = 1; bus.mask_in = 4'b0001;
      cyc();
      bus.mask_we = 0;
      chk("t3 mask same edge no take", 32'(bus.int_take), 0);
      cyc();
      chk("t3 take",  32'(bus.int_take), 1);
      chk("t3 vec",   32'(bus.vec_addr), 32'h3C0);
      chk("t3 id",    32'(bus.active_id), 0);
      do_reti();

      // No nesting; pending keeps accumulating during service
      set_mask(4'hF);
      bus.irq = 4'b0100;
      cyc();
      bus.irq = 0; bus.inst_boundary = 1; bus.pc_in = 10'h055;
      cyc();
      chk("t4 first take", 32'(bus.int_take), 1);
      bus.irq = 4'b0001;
      cyc();
      bus.irq = 0;
      cyc();
      chk("t4 no nest",     32'(bus.int_take), 0);
      chk("t4 pending0",    32'(bus.pending), 32'b0001);
      chk("t4 in_service",  32'(bus.in_service), 1);
      do_reti();
      chk("t4 reti drop",   32'(bus.in_service), 0);
      bus.inst_boundary = 1;
      cyc();
      chk("t4 take0",  32'(bus.int_take), 1);
      chk("t4 id0",    32'(bus.active_id), 0);
      chk("t4 vec0",   32'(bus.vec_addr), 32'h3C0);
      do_reti();

      // A held-high line counts as one request
      takes = 0;
      bus.irq = 4'b0100;
      repeat (10) begin cyc(); if (bus.int_take) takes++; end
      bus.irq = 0;
      chk("t5 pending once", 32'(bus.pending), 32'b0100);
      bus.inst_boundary = 1;
      repeat (4) begin cyc(); if (bus.int_take) takes++; end
      bus.inst_boundary = 0; bus.reti = 1;
      cyc(); if (bus.int_take) takes++;
      bus.reti = 0; bus.inst_boundary = 1;
      repeat (4) begin cyc(); if (bus.int_take) takes++; end
      bus.inst_boundary = 0;
      chk("t5 one take",  32'(takes), 1);
      chk("t5 pending 0", 32'(bus.pending), 0);
      do_reti();

      // Asynchronous reset during service
      bus.irq = 4'b1000;
      cyc();
      bus.irq = 4'b0010; bus.inst_boundary = 1; bus.pc_in = 10'h3FF;
      cyc();
      bus.irq = 0; bus.inst_boundary = 0;
      chk("t6 take", 32'(bus.int_take), 1);
      @(posedge clk);
      #2 reset = 1;
      #1;
      chk("t6 rst int_take",   32'(bus.int_take), 0);
      chk("t6 rst in_service", 32'(bus.in_service), 0);
      chk("t6 rst vec_addr",   32'(bus.vec_addr), 0);
      chk("t6 rst ret_addr",   32'(bus.ret_addr), 0);
      chk("t6 rst active_id",  32'(bus.active_id), 0);
      chk("t6 rst pending",    32'(bus.pending), 0);
      cyc();
      reset = 0;
      takes = 0;
      repeat (3) begin cyc(); if (bus.int_take || bus.in_service) takes++; end
      chk("t6 nothing after reset", 32'(takes), 0);

      // Line high across reset release registers as one edge
      reset = 1; bus.irq = 4'b0010;
      cyc();
      reset = 0;
      cyc();
      chk("t7 edge at release", 32'(bus.pending), 32'b0010);
      bus.irq = 0;
      cyc();

      // Randomized traffic, checked by the compare process
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(5) == 0) bus.irq[b] = ~bus.irq[b];
         bus.mask_we       = ($urandom_range(7) == 0);
         bus.mask_in       = 4'($urandom);
         bus.inst_boundary = 1'($urandom);
         bus.pc_in         = PC_W'($urandom);
         bus.reti          = ($urandom_range(3) == 0);
         reset             = ($urandom_range(399) == 0);
         cyc();
      end
      reset = 0;
      idle_inputs();
      repeat (2) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
